// File: rtl/alu_arbiter.sv
// alu_arbiter: one team ALU time-shared round-robin between two requesters.
// Define ALU_ARB_FAST_EN to drop EXEC and answer one cycle after accept.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module alu (
    input  logic [2:0]             op,
    input  logic [`DATA_WIDTH-1:0] a,
    input  logic [`DATA_WIDTH-1:0] b,
    output logic [`DATA_WIDTH-1:0] result,
    output logic                   zero,
    output logic                   carry_out,
    output logic                   overflow
);
    localparam int W = `DATA_WIDTH;

    logic         binv;
    logic [W-1:0] b_eff;
    logic [W:0]   sum;
    logic         ovf_raw;
    logic         arith;

    always_comb begin
        binv    = op[2];
        b_eff   = binv ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, binv};
        ovf_raw = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
        arith   = (op == 3'b010) || (op == 3'b110);
        case (op)
            3'b000:  result = a & b;
            3'b001:  result = a | b;
            3'b010:  result = sum[W-1:0];
            3'b110:  result = sum[W-1:0];
            3'b111:  result = {{(W-1){1'b0}}, sum[W-1] ^ ovf_raw};
            default: result = '0;
        endcase
        carry_out = sum[W];
        overflow  = arith && ovf_raw;
        zero      = (result == '0);
    end
endmodule

module alu_arbiter (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [2*`DATA_WIDTH+2:0] req0_data,
    output logic                     resp0_valid,
    input  logic                     resp0_ready,
    output logic [`DATA_WIDTH+2:0]   resp0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [2*`DATA_WIDTH+2:0] req1_data,
    output logic                     resp1_valid,
    input  logic                     resp1_ready,
    output logic [`DATA_WIDTH+2:0]   resp1_data
);
    localparam int W = `DATA_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
`ifndef ALU_ARB_FAST_EN
    localparam logic [1:0] EXEC = 2'd1;
`endif
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]     state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           gnt_q, gnt_d;
    logic [W+2:0]   resp_q, resp_d;

    logic           any_valid;
    logic           gnt_sel;
    logic           idle;
    logic [2*W+2:0] sel_data;

    logic [2:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_res;
    logic           alu_zero;
    logic           alu_cout;
    logic           alu_ovf;
    logic [W+2:0]   alu_pack;

`ifndef ALU_ARB_FAST_EN
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
`endif

    always_comb begin
        any_valid = req0_valid | req1_valid;
        // Pointer only matters on contention; a lone requester always wins.
        gnt_sel   = (req0_valid & req1_valid) ? ptr_q : req1_valid;
        idle      = (state_q == IDLE);
        sel_data  = gnt_sel ? req1_data : req0_data;
    end

    assign req0_ready  = rst_n & idle & any_valid & ~gnt_sel;
    assign req1_ready  = rst_n & idle & any_valid & gnt_sel;
    assign resp0_valid = (state_q == RESP) & ~gnt_q;
    assign resp1_valid = (state_q == RESP) & gnt_q;
    assign resp0_data  = resp0_valid ? resp_q : '0;
    assign resp1_data  = resp1_valid ? resp_q : '0;

`ifdef ALU_ARB_FAST_EN
    always_comb begin
        alu_op = sel_data[2*W+2:2*W];
        alu_a  = sel_data[2*W-1:W];
        alu_b  = sel_data[W-1:0];
    end
`else
    always_comb begin
        alu_op = op_q;
        alu_a  = a_q;
        alu_b  = b_q;
    end
`endif

    alu u_alu (
        .op        (alu_op),
        .a         (alu_a),
        .b         (alu_b),
        .result    (alu_res),
        .zero      (alu_zero),
        .carry_out (alu_cout),
        .overflow  (alu_ovf)
    );

    assign alu_pack = {alu_ovf, alu_cout, alu_zero, alu_res};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        resp_d  = resp_q;
`ifndef ALU_ARB_FAST_EN
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    gnt_d = gnt_sel;
`ifdef ALU_ARB_FAST_EN
                    resp_d  = alu_pack;
                    state_d = RESP;
`else
                    op_d    = sel_data[2*W+2:2*W];
                    a_d     = sel_data[2*W-1:W];
                    b_d     = sel_data[W-1:0];
                    state_d = EXEC;
`endif
                end
            end
`ifndef ALU_ARB_FAST_EN
            EXEC: begin
                resp_d  = alu_pack;
                state_d = RESP;
            end
`endif
            RESP: begin
                // Fairness moves on completion, so a stalled response keeps its turn.
                if (gnt_q ? resp1_ready : resp0_ready) begin
                    state_d = IDLE;
                    ptr_d   = ~gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            resp_q  <= '0;
`ifndef ALU_ARB_FAST_EN
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            resp_q  <= resp_d;
`ifndef ALU_ARB_FAST_EN
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;

`ifdef ALU_ARB_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [66:0] req0_data = '0, req1_data = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [34:0] resp0_data, resp1_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_data  (resp0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_data  (resp1_data)
    );

    typedef struct {
        int          r;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] exp;
    } vec_t;

    // Reference ALU from arithmetic rules: signed/unsigned math in 64 bits.
    function automatic logic [34:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, s;
        logic [63:0] t;
        logic [31:0] r;
        logic        c, o;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        o  = 1'b0;
        if (op[2]) begin
            c = (a >= b);
        end else begin
            t = 64'(a) + 64'(b);
            c = t[32];
        end
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = sa + sb;
                r = 32'(s);
                o = (s != longint'($signed(r)));
            end
            3'b110: begin
                s = sa - sb;
                r = 32'(s);
                o = (s != longint'($signed(r)));
            end
            3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {o, c, (r == 32'd0), r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int r);
        return (r != 0) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rv(input int r);
        return (r != 0) ? resp1_valid : resp0_valid;
    endfunction

    // Entry and exit: 1 time unit after a rising edge, DUT idle.
    task automatic txn(input int r, input logic [66:0] d,
                       output logic [34:0] got, output int lat);
        int k;
        if (r != 0) begin req1_valid = 1'b1; req1_data = d; end
        else begin req0_valid = 1'b1; req0_data = d; end
        k = 0;
        @(negedge clk);
        while (!rdy(r) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("txn_accept", 64'(rdy(r)), 64'd1);
        chk("txn_ready_excl", 64'(rdy(1 - r)), 64'd0);
        @(posedge clk);
        #1;
        if (r != 0) begin req1_valid = 1'b0; req1_data = ~d; end
        else begin req0_valid = 1'b0; req0_data = ~d; end
        lat = 1;
        @(negedge clk);
        while (!rv(r) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        got = (r != 0) ? resp1_data : resp0_data;
        chk("txn_resp_other", 64'(rv(1 - r)), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int r, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!rdy(r) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(rdy(r)), 64'd1);
    endtask

    task automatic wait_resp(input int r, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!rv(r) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(rv(r)), 64'd1);
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_rdy"}, 64'({req1_ready, req0_ready}), 64'd0);
        chk({name, "_rv"}, 64'({resp1_valid, resp0_valid}), 64'd0);
        chk({name, "_rd0"}, 64'(resp0_data), 64'd0);
        chk({name, "_rd1"}, 64'(resp1_data), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[10];
        logic [34:0] got;
        int          lat;
        int          g[3];
        int          ng;
        logic [34:0] e0, e1;

        tbl[0] = '{0, 3'b010, 32'h7FFFFFFF, 32'h00000001, {1'b1, 1'b0, 1'b0, 32'h80000000}};
        tbl[1] = '{1, 3'b110, 32'h00000005, 32'h00000005, {1'b0, 1'b1, 1'b1, 32'h00000000}};
        tbl[2] = '{0, 3'b000, 32'hFFFF0000, 32'h0000FFFF, {1'b0, 1'b0, 1'b1, 32'h00000000}};
        tbl[3] = '{1, 3'b001, 32'h000000F0, 32'h0000000F, {1'b0, 1'b0, 1'b0, 32'h000000FF}};
        tbl[4] = '{0, 3'b111, 32'hFFFFFFFF, 32'h00000001, {1'b0, 1'b1, 1'b0, 32'h00000001}};
        tbl[5] = '{1, 3'b111, 32'h00000001, 32'hFFFFFFFF, {1'b0, 1'b0, 1'b1, 32'h00000000}};
        tbl[6] = '{0, 3'b011, 32'hFFFFFFFF, 32'h00000001, {1'b0, 1'b1, 1'b1, 32'h00000000}};
        tbl[7] = '{1, 3'b100, 32'h00000003, 32'h00000005, {1'b0, 1'b0, 1'b1, 32'h00000000}};
        tbl[8] = '{0, 3'b110, 32'h80000000, 32'h00000001, {1'b1, 1'b1, 1'b0, 32'h7FFFFFFF}};
        tbl[9] = '{1, 3'b010, 32'hFFFFFFFF, 32'h00000001, {1'b0, 1'b1, 1'b1, 32'h00000000}};

        // Reset with both requesters already asking: nothing may be accepted.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #3;
        check_zero_outputs("reset");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round robin with both valid continuously.
        req0_data  = {3'b111, 32'hFFFFFFFF, 32'h00000001};
        req1_data  = {3'b001, 32'h000000F0, 32'h0000000F};
        e0 = model(3'b111, 32'hFFFFFFFF, 32'h00000001);
        e1 = model(3'b001, 32'h000000F0, 32'h0000000F);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        g  = '{-1, -1, -1};
        ng = 0;
        for (int k = 0; k < 40 && ng < 3; k++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("rr_excl", 64'(req0_ready & req1_ready), 64'd0);
                g[ng] = int'(req1_ready);
                ng++;
            end
            if (resp0_valid) chk("rr_resp0", 64'(resp0_data), 64'(e0));
            if (resp1_valid) chk("rr_resp1", 64'(resp1_data), 64'(e1));
        end
        chk("rr_grants", 64'(ng), 64'd3);
        chk("rr_first", 64'(g[0]), 64'd0);
        chk("rr_second", 64'(g[1]), 64'd1);
        chk("rr_third", 64'(g[2]), 64'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Vector table, one requester at a time.
        for (int i = 0; i < 10; i++) begin
            txn(tbl[i].r, {tbl[i].op, tbl[i].a, tbl[i].b}, got, lat);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(LAT));
            chk($sformatf("tbl%0d_data", i), 64'(got), 64'(tbl[i].exp));
        end

        // Stalled response: data holds, other requester waits.
        resp0_ready = 1'b0;
        req0_valid  = 1'b1;
        req0_data   = {3'b010, 32'd1, 32'd2};
        e0 = model(3'b010, 32'd1, 32'd2);
        e1 = model(3'b110, 32'd10, 32'd3);
        wait_ready(0, "hold_accept");
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req0_data  = '1;
        req1_valid = 1'b1;
        req1_data  = {3'b110, 32'd10, 32'd3};
        wait_resp(0, "hold_resp");
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_valid", 64'(resp0_valid), 64'd1);
            chk("hold_data", 64'(resp0_data), 64'(e0));
            chk("hold_req1_ready", 64'(req1_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        resp0_ready = 1'b1;
        @(negedge clk);
        chk("hs_req1_ready", 64'(req1_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_hs_req1_ready", 64'(req1_ready), 64'd1);
        chk("after_hs_req0_ready", 64'(req0_ready), 64'd0);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_resp(1, "hold_resp1");
        chk("hold_resp1_data", 64'(resp1_data), 64'(e1));
        @(posedge clk);
        #1;

        // Reset while req0 is in flight; pointer first moved to req1.
        txn(0, {3'b010, 32'd4, 32'd4}, got, lat);
        chk("pre_rst_data", 64'(got), 64'(model(3'b010, 32'd4, 32'd4)));
        req0_valid = 1'b1;
        req0_data  = {3'b010, 32'h7FFFFFFF, 32'h00000001};
        wait_ready(0, "mid_accept");
        @(posedge clk);
        #1;
        req1_valid = 1'b1;
        req1_data  = {3'b001, 32'd1, 32'd2};
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 64'({req1_ready, req0_ready}), 64'b01);
        chk("post_rst_rv", 64'({resp1_valid, resp0_valid}), 64'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Randomized traffic against a transaction-level model.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            bit          busy;
            bit          ptr_m;
            bit          gm;
            int          acc;
            logic [34:0] exp_d;
            logic [31:0] ra, rb;
            logic [1:0]  eg;
            busy  = 1'b0;
            ptr_m = 1'b0;
            gm    = 1'b0;
            acc   = 0;
            exp_d = '0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(posedge clk);
                #1;
                for (int q = 0; q < 2; q++) begin
                    ra = $urandom();
                    rb = $urandom();
                    case ($urandom_range(0, 5))
                        1: ra = 32'h7FFFFFFF;
                        2: ra = 32'h80000000;
                        3: ra = 32'hFFFFFFFF;
                        default: ;
                    endcase
                    case ($urandom_range(0, 5))
                        1: rb = 32'h00000001;
                        2: rb = ra;
                        3: rb = 32'h80000000;
                        default: ;
                    endcase
                    if (q == 0) begin
                        req0_valid = ($urandom_range(0, 9) < 6);
                        req0_data  = {3'($urandom_range(0, 7)), ra, rb};
                    end else begin
                        req1_valid = ($urandom_range(0, 9) < 6);
                        req1_data  = {3'($urandom_range(0, 7)), ra, rb};
                    end
                end
                resp0_ready = $urandom_range(0, 1) != 0;
                resp1_ready = $urandom_range(0, 1) != 0;
                @(negedge clk);
                if (busy) begin
                    eg = 2'b00;
                end else if (req0_valid && req1_valid) begin
                    eg = ptr_m ? 2'b10 : 2'b01;
                end else begin
                    eg = {req1_valid, req0_valid};
                end
                chk("rnd_grant", 64'({req1_ready, req0_ready}), 64'(eg));
                if (!busy && (req0_ready || req1_ready)) begin
                    busy  = 1'b1;
                    gm    = req1_ready;
                    acc   = cyc;
                    exp_d = gm ? model(req1_data[66:64], req1_data[63:32], req1_data[31:0])
                               : model(req0_data[66:64], req0_data[63:32], req0_data[31:0]);
                end
                if (busy && (cyc - acc) >= LAT) begin
                    chk("rnd_resp_valid", 64'({resp1_valid, resp0_valid}),
                        gm ? 64'b10 : 64'b01);
                    chk("rnd_resp_data", 64'(gm ? resp1_data : resp0_data), 64'(exp_d));
                    if (gm ? resp1_ready : resp0_ready) begin
                        busy  = 1'b0;
                        ptr_m = ~gm;
                    end
                end else begin
                    chk("rnd_resp_idle", 64'({resp1_valid, resp0_valid}), 64'd0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
